// File: rtl/entropy_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : entropy_word_fifo
// Brief    : Packs OHT-approved raw ADC bits into words held in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_word_fifo #(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adc_in,
  input  logic                     oht_valid,
  input  logic                     inter_fail,
  input  logic                     perm_fail,
  input  logic                     deque,
  output logic [WORD_W-1:0]        rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     locked,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                locked_q, locked_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_bit_ok;
  logic                w_accept;
  logic                w_push;
  logic                w_drop;
  logic [WORD_W-1:0]   w_word;

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == DEPTH_CNT);
  assign w_pop    = deque && !w_empty && (state_q != S_LOCK);
  // A bit is offered only in FILL with no fail pending; full blocks it unless a pop frees a slot.
  assign w_bit_ok = (state_q == S_FILL) && oht_valid && !inter_fail && !perm_fail;
  assign w_accept = w_bit_ok && (!w_full || w_pop);
  assign w_drop   = w_bit_ok && w_full && !w_pop;
  assign w_push   = w_accept && (bit_cnt_q == LAST_BIT);
  assign w_word   = {sh_q[WORD_W-2:0], adc_in};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (oht_valid) state_d = S_FILL;
      S_FILL:  if (!oht_valid) state_d = S_IDLE;
      S_LOCK:  state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
    if (perm_fail) state_d = S_LOCK;
  end

  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    locked_d  = locked_q;
    drop_d    = drop_q;
    if (perm_fail) begin
      sh_d      = '0;
      bit_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      locked_d  = 1'b1;
    end else if (state_q != S_LOCK) begin
      if (inter_fail) begin
        sh_d      = '0;
        bit_cnt_d = '0;
      end else if (w_accept) begin
        sh_d      = w_word;
        bit_cnt_d = w_push ? '0 : bit_cnt_q + BIT_W'(1);
      end
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (w_drop && (drop_q != DROP_MAX)) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      locked_q  <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      locked_q  <= locked_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: rdata is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) mem_q[wr_ptr_q] <= w_word;
  end

  assign rdata    = w_empty ? '0 : mem_q[rd_ptr_q];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = count_q;
  assign locked   = locked_q;
  assign drop_cnt = drop_q;

endmodule
`default_nettype wire
